// File: rtl/div_seq.sv
// div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer beside the execute stage.
// Ports: clk, rst (sync, active-low); start_i/op_i/dividend_i/divisor_i/rd_addr_i
// request from execute; flush_i aborts in START/CALC; busy_o, hold_req_o stall
// pipeline; ready_o/result_o/rd_addr_o/rd_wen_o write-back, valid only in END.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        hold_req_o,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;
    state_t state, state_n;
    logic        is_signed, is_rem, neg_q, neg_r;
    logic [31:0] dvd, dvs, dvs_mag, quot, rem;
    logic [4:0]  rd;
    logic [5:0]  cnt;
    logic        accept, div_zero, ovf, special, ge;
    logic [31:0] mag_a, mag_b, diff, q_fix, r_fix;
    logic [32:0] rem_sh;
    // only 3'b1xx func3 values are divide ops
    assign accept   = start_i & ~flush_i & op_i[2];
    assign div_zero = dvs == 32'd0;
    assign ovf      = is_signed & (dvd == 32'h8000_0000) & (dvs == 32'hFFFF_FFFF);
    assign special  = div_zero | ovf;
    assign mag_a    = (is_signed & dvd[31]) ? -dvd : dvd;
    assign mag_b    = (is_signed & dvs[31]) ? -dvs : dvs;
    // partial remainder after the shift needs 33 bits for the compare
    assign rem_sh   = {rem, quot[31]};
    assign ge       = rem_sh >= {1'b0, dvs_mag};
    assign diff     = rem_sh[31:0] - dvs_mag;
    assign q_fix    = neg_q ? -quot : quot;
    assign r_fix    = neg_r ? -rem : rem;
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = accept ? S_START : S_IDLE;
            S_START: state_n = flush_i ? S_IDLE : special ? S_END : S_CALC;
            S_CALC:  state_n = flush_i ? S_IDLE : (cnt == 6'd31) ? S_END : S_CALC;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_signed <= 1'b0;
            is_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dvd       <= '0;
            dvs       <= '0;
            dvs_mag   <= '0;
            quot      <= '0;
            rem       <= '0;
            rd        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    is_signed <= ~op_i[0];
                    is_rem    <= op_i[1];
                    dvd       <= dividend_i;
                    dvs       <= divisor_i;
                    rd        <= rd_addr_i;
                end
                S_START: begin
                    // special-case results are final values: no sign fix-up
                    neg_q <= is_signed & (dvd[31] ^ dvs[31]) & ~special;
                    neg_r <= is_signed & dvd[31] & ~special;
                    cnt   <= '0;
                    quot  <= div_zero ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : mag_a;
                    rem   <= div_zero ? dvd : 32'd0;
                    dvs_mag <= mag_b;
                end
                S_CALC: begin
                    rem  <= ge ? diff : rem_sh[31:0];
                    quot <= {quot[30:0], ge};
                    cnt  <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        busy_o     = state != S_IDLE;
        hold_req_o = rst & (((state == S_IDLE) & accept) | (state == S_START) | (state == S_CALC));
        ready_o    = state == S_END;
        rd_wen_o   = state == S_END;
        rd_addr_o  = (state == S_END) ? rd : 5'd0;
        result_o   = (state == S_END) ? (is_rem ? r_fix : q_fix) : 32'd0;
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq with directed and random ops.
module tb_div_seq;
    logic        clk, rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i, divisor_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o, hold_req_o, ready_o, rd_wen_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    int checks = 0, errors = 0;
    div_seq dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .busy_o(busy_o), .hold_req_o(hold_req_o),
        .ready_o(ready_o), .result_o(result_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
    );
    always #5 clk = ~clk;
    logic [2:0]  d_op  [7] = '{3'b101, 3'b110, 3'b100, 3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] d_a   [7] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd123, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [7] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [7] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'd0};
    int          d_lat [7] = '{34, 34, 34, 2, 2, 2, 2};
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            3'b100:  return sa / sb;
            3'b101:  return a / b;
            3'b110:  return sa % sb;
            default: return a % b;
        endcase
    endfunction
    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
    endfunction
    // drives a start in the current cycle; returns one cycle later with garbage operands
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic hold_t);
        start_i = 1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
        @(negedge clk);
        hold_t = hold_req_o;
        @(posedge clk); #1;
        start_i = 0; dividend_i = $urandom; divisor_i = $urandom; op_i = 3'($urandom); rd_addr_i = 5'($urandom);
    endtask
    // counts cycles since the start cycle until ready_o; returns at negedge of END
    task automatic wait_ready(output int lat, output bit hold_ok, output logic [31:0] res,
                              output logic [4:0] rda, output logic wen, output logic hold_end);
        lat = -1; hold_ok = 1; res = 'x; rda = 'x; wen = 0; hold_end = 'x;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k; res = result_o; rda = rd_addr_o; wen = rd_wen_o; hold_end = hold_req_o;
                return;
            end
            if (!hold_req_o) hold_ok = 0;
            @(posedge clk); #1;
        end
    endtask
    task automatic test_reset;
        @(posedge clk); #1;
        rst = 0; start_i = 1; op_i = 3'b101; dividend_i = 32'd50; divisor_i = 32'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_o, hold_req_o, ready_o, rd_wen_o, result_o, rd_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b hold=%b ready=%b wen=%b res=%h rd=%0d expected all 0",
                     busy_o, hold_req_o, ready_o, rd_wen_o, result_o, rd_addr_o);
        end
        @(posedge clk); #1;
        start_i = 0; rst = 1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b expected 0", busy_o); end
        @(posedge clk); #1;
    endtask
    task automatic test_directed;
        int lat; bit hok; logic [31:0] res; logic [4:0] rda; logic wen, hend, ht;
        for (int i = 0; i < 7; i++) begin
            launch(d_op[i], d_a[i], d_b[i], 5'(5 + i), ht);
            wait_ready(lat, hok, res, rda, wen, hend);
            checks++;
            if (lat !== d_lat[i] || res !== d_exp[i]) begin
                errors++;
                $display("FAIL directed_%0d result=%h latency=%0d expected %h latency %0d", i, res, lat, d_exp[i], d_lat[i]);
            end
            checks++;
            if (rda !== 5'(5 + i) || wen !== 1'b1) begin
                errors++;
                $display("FAIL directed_wb_%0d rd=%0d wen=%b expected rd=%0d wen=1", i, rda, wen, 5 + i);
            end
            checks++;
            if (ht !== 1'b1 || !hok || hend !== 1'b0) begin
                errors++;
                $display("FAIL directed_hold_%0d start=%b during=%b end=%b expected 1 1 0", i, ht, hok, hend);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b0 || busy_o !== 1'b0 || rd_wen_o !== 1'b0 || result_o !== 32'd0) begin
                errors++;
                $display("FAIL directed_after_%0d ready=%b busy=%b wen=%b res=%h expected 0", i, ready_o, busy_o, rd_wen_o, result_o);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_random;
        int lat; bit hok; logic [31:0] res, a, b; logic [4:0] rda, rd; logic wen, hend, ht;
        logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 3'(4 + $urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 200));
                default: ;
            endcase
            rd = 5'($urandom);
            launch(op, a, b, rd, ht);
            wait_ready(lat, hok, res, rda, wen, hend);
            checks++;
            if (res !== model(op, a, b) || lat !== model_lat(op, a, b) || rda !== rd || wen !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%h b=%h got %h lat %0d rd %0d expected %h lat %0d rd %0d",
                         i, op, a, b, res, lat, rda, model(op, a, b), model_lat(op, a, b), rd);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_back_to_back;
        int lat; bit hok; logic [31:0] res; logic [4:0] rda; logic wen, hend, ht;
        launch(3'b101, 32'd77, 32'd8, 5'd3, ht);
        wait_ready(lat, hok, res, rda, wen, hend);
        @(posedge clk); #1;
        launch(3'b111, 32'd77, 32'd8, 5'd4, ht);
        wait_ready(lat, hok, res, rda, wen, hend);
        checks++;
        if (ht !== 1'b1 || lat !== 34 || res !== 32'd5 || rda !== 5'd4) begin
            errors++;
            $display("FAIL back_to_back hold=%b lat=%0d res=%h rd=%0d expected 1 34 5 4", ht, lat, res, rda);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_flush;
        int lat; bit hok, bad; logic [31:0] res; logic [4:0] rda; logic wen, hend, ht;
        bad = 0;
        launch(3'b101, 32'd1000, 32'd10, 5'd9, ht);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (ready_o || rd_wen_o) bad = 1;
            @(posedge clk); #1;
        end
        flush_i = 1;
        @(negedge clk);
        if (ready_o || rd_wen_o || !hold_req_o) bad = 1;
        @(posedge clk); #1;
        flush_i = 0;
        start_i = 1; op_i = 3'b101; dividend_i = 32'd9; divisor_i = 32'd3; rd_addr_i = 5'd12;
        @(negedge clk);
        checks++;
        if (bad || busy_o !== 1'b0 || ready_o !== 1'b0 || hold_req_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_abort early_pulse=%b busy=%b ready=%b hold=%b expected 0 0 0 1", bad, busy_o, ready_o, hold_req_o);
        end
        @(posedge clk); #1;
        start_i = 0; dividend_i = $urandom; divisor_i = $urandom;
        wait_ready(lat, hok, res, rda, wen, hend);
        checks++;
        if (lat !== 34 || res !== 32'd3 || rda !== 5'd12) begin
            errors++;
            $display("FAIL flush_restart lat=%0d res=%h rd=%0d expected 34 3 12", lat, res, rda);
        end
        @(posedge clk); #1;
        start_i = 1; flush_i = 1; op_i = 3'b100; dividend_i = 32'd8; divisor_i = 32'd2;
        @(negedge clk);
        checks++;
        if (hold_req_o !== 1'b0) begin errors++; $display("FAIL flush_start_hold hold=%b expected 0", hold_req_o); end
        @(posedge clk); #1;
        start_i = 0; flush_i = 0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_start_busy busy=%b expected 0", busy_o); end
        @(posedge clk); #1;
    endtask
    task automatic test_reset_mid;
        bit bad; logic ht;
        bad = 0;
        launch(3'b100, 32'd500, 32'd7, 5'd20, ht);
        repeat (19) begin @(posedge clk); #1; end
        rst = 0;
        @(negedge clk);
        checks++;
        if (hold_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_hold hold=%b expected 0", hold_req_o); end
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        checks++;
        if ({busy_o, hold_req_o, ready_o, rd_wen_o, result_o, rd_addr_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs busy=%b hold=%b ready=%b wen=%b res=%h rd=%0d expected all 0",
                     busy_o, hold_req_o, ready_o, rd_wen_o, result_o, rd_addr_o);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ready_o || rd_wen_o) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rst_mid_no_writeback pulse=%b expected 0", bad); end
        @(posedge clk); #1;
    endtask
    task automatic test_busy_start;
        int lat; bit hok; logic [31:0] res; logic [4:0] rda; logic wen, hend, ht;
        launch(3'b110, 32'hFFFF_FC00, 32'd13, 5'd17, ht);
        repeat (4) begin @(posedge clk); #1; end
        start_i = 1; op_i = 3'b101; dividend_i = 32'd999; divisor_i = 32'd1; rd_addr_i = 5'd2;
        @(posedge clk); #1;
        start_i = 0;
        wait_ready(lat, hok, res, rda, wen, hend);
        checks++;
        if (lat !== 29 || res !== model(3'b110, 32'hFFFF_FC00, 32'd13) || rda !== 5'd17) begin
            errors++;
            $display("FAIL busy_start lat=%0d res=%h rd=%0d expected 29 %h 17", lat, res, rda, model(3'b110, 32'hFFFF_FC00, 32'd13));
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_start_idle busy=%b expected 0", busy_o); end
        @(posedge clk); #1;
    endtask
    initial begin
        clk = 0; rst = 0; start_i = 0; flush_i = 0; op_i = 0;
        dividend_i = 0; divisor_i = 0; rd_addr_i = 0;
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_busy_start;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) that sit beside the single-cycle execute stage. Execute hands over the decoded operands with a one-cycle start request. The block stalls the pipeline through a hold request, runs a 32-iteration restoring divider, and returns a register write-back (address, data, enable) in the same format execute uses. Flush from the jump/branch control aborts an operation in flight.

## Interface
- XLEN, 32, operand/result width; fixed, not for override.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- start_i  in  1  request from execute; operands valid this cycle.
- op_i  in  3  func3 of the instruction: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
- dividend_i  in  32  op1 (rs1 value).
- divisor_i  in  32  op2 (rs2 value).
- rd_addr_i  in  5  destination register.
- flush_i  in  1  pipeline kill from jump/branch control.
- busy_o  out  1  high while state is not IDLE.
- hold_req_o  out  1  stall request to pipeline control.
- ready_o  out  1  one-cycle pulse: result valid.
- result_o  out  32  quotient or remainder.
- rd_addr_o  out  5  write-back address.
- rd_wen_o  out  1  write-back enable.

## Operation
- FSM states: IDLE, START, CALC, END. Reset forces IDLE.
- **IDLE:**
  - start_i=1 and flush_i=0: latch op_i, both operands and rd_addr_i, then go to START.
  - Otherwise stay in IDLE.
  - op_i values other than 3'b1xx are ignored.
- **START:** if flush_i=1, go to IDLE. Otherwise check the special cases below in priority order:
  - divisor==0: quotient=32'hFFFF_FFFF, remainder=dividend; go to END.
  - Signed op, dividend==32'h8000_0000 and divisor==32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0; go to END.
  - Otherwise:
    - Load the magnitudes: absolute value for signed ops, raw value for unsigned.
    - Clear the 32-bit partial remainder and the 6-bit iteration counter.
    - Go to CALC.
- **CALC:** one restoring step per cycle.
  - Shift {rem, quot} left by 1.
  - If shifted rem >= divisor magnitude: subtract the divisor and set quot[0]=1.
  - Counter increments each step. After the 32nd step (counter==31 at that edge), go to END.
  - If flush_i=1, go to IDLE and discard the operation.
- **END:** always go to IDLE next cycle; flush_i is ignored in END because the result has already committed.
- Sign fix-up, applied when the END outputs are registered:
  - DIV: quotient is negated if the dividend and divisor signs differ.
  - REM: remainder takes the sign of the dividend.
  - Unsigned ops: no fix-up.
- Operand and op inputs are ignored while busy_o=1; start_i while busy is dropped.
- hold_req_o = (state==IDLE & start_i & ~flush_i) | state==START | state==CALC.
  - Deasserts in END so the pipeline advances in the cycle the result is written.
  - Forced to 0 while rst=0.
- Outside END, result_o, rd_addr_o and rd_wen_o are 0 (same zero-default convention as execute).

## Timing
- Reset value of every output is 0. Reset mid-operation returns to IDLE next edge with no ready and no write.
- Start sampled at edge T (IDLE, start_i=1). Then:
  - START occupies T+1.
  - CALC occupies T+2..T+33.
  - END occupies T+34: ready_o=1, rd_wen_o=1, result_o valid.
  - IDLE at T+35.
- Special cases (divide by zero, signed overflow): START at T+1, END at T+2.
- The earliest next accepted start is at the IDLE cycle following END (T+35 normal, T+3 special).
- flush_i in START or CALC at cycle F: IDLE at F+1. No ready_o or rd_wen_o pulse for that operation.
- flush_i and start_i together in IDLE: the start is ignored and hold_req_o stays 0.
- ready_o is high for exactly one cycle per completed operation.

## Test plan
- DIVU 100/7, rd=5 -> ready_o at T+34 with result_o=14, rd_addr_o=5, rd_wen_o=1; hold_req_o high T..T+33 and low at T+34.
- REM -7 % 2 (32'hFFFF_FFF9, 2) -> result_o=32'hFFFF_FFFF at T+34. DIV -7/2 -> 32'hFFFF_FFFD.
- DIV x/0 -> 32'hFFFF_FFFF at T+2. REMU 123/0 -> 123 at T+2.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000 at T+2. REM with the same operands -> 0.
- DIVU 1000/10 with flush_i pulsed at T+10 -> IDLE at T+11, no ready_o or rd_wen_o. A new DIVU 9/3 started at T+11 -> result_o=3 at T+45.
- rst=0 at T+20 during CALC -> all outputs 0 at T+21. A start_i pulse during busy (T+5) leaves the result of the first operation unchanged.
